// File: rtl/tick_sched_pkg.sv
// Shared register map and default widths for the tick scheduler.
package tick_sched_pkg;
  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_STATUS   = 1;
  localparam int ADDR_DIV_BASE = 2;
  localparam int CNT_W_DEF     = 24;
endpackage

// File: rtl/tick_chan.sv
// One scheduler channel: counter, terminal-count compare, tick pulse and sclk toggle.
module tick_chan #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             div_wr,
  output logic             fire,
  output logic             tick,
  output logic             sclk
);
  logic [CNT_W-1:0] cnt;

  // A DIV write in the matching cycle suppresses the fire.
  assign fire = en && (cnt == div) && !div_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      sclk <= 1'b0;
    end else begin
      tick <= fire;
      if (!en || div_wr || fire) cnt <= '0;
      else                       cnt <= cnt + CNT_W'(1);
      if (!en)       sclk <= 1'b0;
      else if (fire) sclk <= ~sclk;
    end
  end
endmodule

// File: rtl/tick_sched.sv
// Multi-channel clock-enable scheduler with MMIO CTRL/STATUS/DIV registers.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          addr,
  input  logic [31:0]         wdata,
  input  logic                we,
  input  logic                re,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sclk,
  output logic                irq
);
  logic [CHANNELS-1:0]            en, oneshot, status, fire, div_wr;
  logic [CHANNELS-1:0][CNT_W-1:0] div;
  logic                           ctrl_wr, stat_wr;
  logic [31:0]                    rd;

  assign ctrl_wr = we && (addr == 4'(ADDR_CTRL));
  assign stat_wr = we && (addr == 4'(ADDR_STATUS));

  generate
    if (CNT_W < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^wdata[31:CNT_W];
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      assign div_wr[g] = we && (addr == 4'(ADDR_DIV_BASE + g));
      tick_chan #(.CNT_W(CNT_W)) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en[g]),
        .div    (div[g]),
        .div_wr (div_wr[g]),
        .fire   (fire[g]),
        .tick   (tick[g]),
        .sclk   (sclk[g])
      );
    end
  endgenerate

  always_comb begin
    rd = '0;
    if (addr == 4'(ADDR_CTRL))   rd[2*CHANNELS-1:0] = {oneshot, en};
    if (addr == 4'(ADDR_STATUS)) rd[CHANNELS-1:0]   = status;
    for (int i = 0; i < CHANNELS; i++)
      if (addr == 4'(ADDR_DIV_BASE + i)) rd[CNT_W-1:0] = div[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      oneshot <= '0;
      status  <= '0;
      irq     <= 1'b0;
      rdata   <= '0;
      for (int i = 0; i < CHANNELS; i++) div[i] <= CNT_W'(DEFAULT_DIV);
    end else begin
      // Software CTRL writes override the one-shot auto-clear.
      if (ctrl_wr) begin
        en      <= wdata[CHANNELS-1:0];
        oneshot <= wdata[2*CHANNELS-1:CHANNELS];
      end else begin
        en <= en & ~(fire & oneshot);
      end
      status <= (status & ~(stat_wr ? wdata[CHANNELS-1:0] : '0)) | fire;
      irq    <= |status;
      for (int i = 0; i < CHANNELS; i++)
        if (div_wr[i]) div[i] <= wdata[CNT_W-1:0];
      if (re) rdata <= rd;
    end
  end
endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: register access, tick timing, one-shot, W1C and reset.
module tb_tick_sched;
  logic        clk, rst_n, we, re;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  tick, sclk;
  logic        irq;
  int n_chk, n_fail, cnt;

  tick_sched dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .tick(tick), .sclk(sclk), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a; re = 1'b1;
    cyc(1);
    re = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    #3 rst_n = 1'b0;
    cyc(2);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_irq",  32'(irq), 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    cyc(1);
    rd(4'd0); chk("rst_ctrl", rdata, 0);
    rd(4'd1); chk("rst_status", rdata, 0);
    rd(4'd2); chk("rst_div0", rdata, 32'd100000);

    // Channel 0, DIV=3: fires every 4 cycles
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h1);
    cyc(3); chk("c0_pre_tick", 32'(tick[0]), 0);
    cyc(1); chk("c0_tick1", 32'(tick[0]), 1); chk("c0_sclk1", 32'(sclk[0]), 1);
    chk("c0_irq_lag", 32'(irq), 0);
    cyc(1); chk("c0_tick_drop", 32'(tick[0]), 0); chk("c0_irq", 32'(irq), 1);
    cyc(3); chk("c0_tick2", 32'(tick[0]), 1); chk("c0_sclk2", 32'(sclk[0]), 0);
    cyc(4); chk("c0_tick3", 32'(tick[0]), 1); chk("c0_sclk3", 32'(sclk[0]), 1);
    cyc(3);
    // W1C coincident with a fire: set wins
    wr(4'd1, 32'h1);
    chk("c0_tick4", 32'(tick[0]), 1);
    rd(4'd1); chk("w1c_vs_fire", rdata, 32'h1);
    wr(4'd0, 32'h0);
    wr(4'd1, 32'h1);
    cyc(1); chk("w1c_irq_drop", 32'(irq), 0);
    rd(4'd1); chk("w1c_status", rdata, 0);
    chk("c0_off_sclk", 32'(sclk[0]), 0);

    // Channel 1 one-shot with DIV=0
    wr(4'd3, 32'd0);
    wr(4'd0, 32'h22);
    chk("os_pre", 32'(tick[1]), 0);
    cyc(1); chk("os_tick", 32'(tick[1]), 1); chk("os_sclk", 32'(sclk[1]), 1);
    cyc(1); chk("os_sclk_low", 32'(sclk[1]), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (tick[1]) cnt++;
    end
    chk("os_no_more", 32'(cnt), 0);
    rd(4'd0); chk("os_ctrl", rdata, 32'h20);
    chk("os_irq", 32'(irq), 1);

    // Channel 2: DIV rewrite mid-count, then coincident with a match
    wr(4'd4, 32'd20);
    wr(4'd0, 32'h04);
    cyc(7);
    wr(4'd4, 32'd10);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (tick[2]) cnt++;
    end
    chk("div_wr_quiet", 32'(cnt), 0);
    cyc(1); chk("div_wr_tick", 32'(tick[2]), 1);
    cyc(10);
    wr(4'd4, 32'd10);
    chk("div_wr_match", 32'(tick[2]), 0);
    cyc(10); chk("div_match_pre", 32'(tick[2]), 0);
    cyc(1); chk("div_match_next", 32'(tick[2]), 1);

    // DIV upper bits, read-during-write, rdata hold, unmapped read
    wr(4'd5, 32'hFF00_0005);
    rd(4'd5); chk("div3_upper", rdata, 32'h5);
    addr = 4'd5; wdata = 32'd7; we = 1'b1; re = 1'b1;
    cyc(1);
    we = 1'b0; re = 1'b0;
    chk("rd_during_wr", rdata, 32'h5);
    rd(4'd5); chk("div3_new", rdata, 32'h7);
    cyc(3); chk("rdata_hold", rdata, 32'h7);
    rd(4'd15); chk("unmapped", rdata, 0);

    // Async reset mid-period while sclk[0]=1
    wr(4'd0, 32'h1);
    cyc(4); chk("pre_rst_sclk", 32'(sclk[0]), 1);
    cyc(1);
    rst_n = 1'b0;
    #2;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_sclk", 32'(sclk), 0);
    chk("arst_irq",  32'(irq), 0);
    chk("arst_rdata", rdata, 0);
    cyc(1);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (tick != 0 || sclk != 0) cnt++;
    end
    chk("post_rst_idle", 32'(cnt), 0);
    rd(4'd0); chk("post_rst_ctrl", rdata, 0);
    rd(4'd2); chk("post_rst_div0", rdata, 32'd100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
